// File: rtl/rhd_acq_sequencer.sv
// RHD2132 command scheduler: config writes, calibration, then CONVERT
// round-robin with re-tagging of the chip's two-deep result pipeline.
module rhd_acq_sequencer #(
  parameter int          NUM_CFG    = 18,
  parameter int          NUM_CH     = 32,
  parameter int          NUM_CALDUM = 9,
  parameter logic [15:0] DUMMY_CMD  = 16'hE800
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic [4:0]  cfg_addr,
  input  logic [13:0] cfg_data,
  output logic        cmd_valid,
  output logic [15:0] cmd_data,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_data,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [4:0]  sample_chan,
  output logic        frame_start,
  output logic        busy,
  output logic        config_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_CAL,
    S_CALDUM,
    S_SCAN,
    S_FLUSH
  } state_t;

  localparam logic [4:0]  LAST_CFG = 5'(NUM_CFG - 1);
  localparam logic [4:0]  LAST_CH  = 5'(NUM_CH - 1);
  localparam logic [3:0]  LAST_DUM = 4'(NUM_CALDUM - 1);
  localparam logic [15:0] CAL_CMD  = 16'h5500;

  state_t      state;
  state_t      state_n;
  logic        pend;
  logic        fin;
  logic        stop_lat;
  logic [4:0]  idx;
  logic [4:0]  ch;
  logic [3:0]  dcnt;
  logic [5:0]  tag;
  logic [5:0]  cur_tag;
  logic [5:0]  t1;
  logic [5:0]  t2;
  logic        acc;
  logic        rsp_fire;
  logic        issue;
  logic        go;
  logic        done;
  logic [15:0] next_cmd;

  assign acc         = cmd_valid & cmd_ready;
  assign rsp_fire    = rsp_valid & pend;
  assign issue       = (state != S_IDLE) & ~pend & ~cmd_valid;
  assign go          = (state == S_IDLE) & start;
  assign done        = (state == S_FLUSH) & (state_n == S_IDLE);
  assign tag         = {state == S_SCAN, ch};
  assign busy        = (state != S_IDLE);
  assign config_done = (state == S_SCAN);
  assign cfg_addr    = idx;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_CFG;
      end
      S_CFG: begin
        if (rsp_fire && idx == LAST_CFG) state_n = S_CAL;
      end
      S_CAL: begin
        if (rsp_fire) state_n = S_CALDUM;
      end
      S_CALDUM: begin
        if (rsp_fire && dcnt == LAST_DUM) state_n = S_SCAN;
      end
      S_SCAN: begin
        if (rsp_fire && fin) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if (rsp_fire && dcnt == 4'd1) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    next_cmd = DUMMY_CMD;
    unique case (state)
      S_CFG:   next_cmd = {2'b10, cfg_data};
      S_CAL:   next_cmd = CAL_CMD;
      S_SCAN:  next_cmd = {3'b000, ch, 8'h00};
      default: next_cmd = DUMMY_CMD;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      cmd_valid    <= 1'b0;
      cmd_data     <= 16'h0000;
      pend         <= 1'b0;
      fin          <= 1'b0;
      stop_lat     <= 1'b0;
      idx          <= 5'd0;
      ch           <= 5'd0;
      dcnt         <= 4'd0;
      cur_tag      <= 6'd0;
      t1           <= 6'd0;
      t2           <= 6'd0;
      sample_valid <= 1'b0;
      sample_data  <= 16'h0000;
      sample_chan  <= 5'd0;
      frame_start  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;

      if (issue) begin
        cmd_valid <= 1'b1;
        cmd_data  <= next_cmd;
      end

      if (acc) begin
        cmd_valid <= 1'b0;
        pend      <= 1'b1;
        cur_tag   <= tag;
        if (state == S_SCAN) begin
          ch  <= (ch == LAST_CH) ? 5'd0 : ch + 5'd1;
          fin <= (ch == LAST_CH) & stop_lat;
        end
      end

      // the word returned now carries the result of the command two back
      if (rsp_fire) begin
        pend <= 1'b0;
        t2   <= t1;
        t1   <= cur_tag;
        if (t2[5]) begin
          sample_valid <= 1'b1;
          sample_data  <= rsp_data;
          sample_chan  <= t2[4:0];
          frame_start  <= (t2[4:0] == 5'd0);
        end
        unique case (state)
          S_CFG: begin
            if (idx != LAST_CFG) idx <= idx + 5'd1;
          end
          S_CAL: begin
            dcnt <= 4'd0;
          end
          S_CALDUM: begin
            if (dcnt == LAST_DUM) ch <= 5'd0;
            else                  dcnt <= dcnt + 4'd1;
          end
          S_SCAN: begin
            if (fin) dcnt <= 4'd0;
          end
          S_FLUSH: begin
            dcnt <= dcnt + 4'd1;
          end
          default: begin
          end
        endcase
      end

      if (busy && stop) stop_lat <= 1'b1;

      if (go) begin
        idx      <= 5'd0;
        ch       <= 5'd0;
        dcnt     <= 4'd0;
        t1       <= 6'd0;
        t2       <= 6'd0;
        fin      <= 1'b0;
        pend     <= 1'b0;
        stop_lat <= 1'b0;
      end

      if (done) begin
        stop_lat <= 1'b0;
        fin      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rhd_acq_sequencer.sv
// Bench for rhd_acq_sequencer: SPI engine model, command sequence tables
// and a sample scoreboard fed as responses are driven.
module tb_rhd_acq_sequencer;

  typedef struct {
    logic [13:0] cfg;
    logic [15:0] exp;
  } vec_t;

  typedef struct packed {
    logic [4:0]  ch;
    logic [15:0] d;
    logic        fs;
  } samp_t;

  logic        clk25;
  logic        rst;
  logic        start;
  logic        stop;
  logic [4:0]  cfg_addr;
  logic [13:0] cfg_data;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [4:0]  sample_chan;
  logic        frame_start;
  logic        busy;
  logic        config_done;

  vec_t        vec [13];
  logic [13:0] cfg_tab [32];
  logic [15:0] acc_q [$];
  samp_t       samp_q [$];

  int          total;
  int          bad;
  int          cnt;
  int          hold_cnt;
  int          k;
  int          nsamp;
  logic        spur_req;
  logic        prev_stall;
  logic [15:0] prev_word;
  logic [15:0] h1;
  logic [15:0] h2;
  logic [15:0] cur;
  logic [4:0]  first_chan;
  logic [4:0]  last_chan;
  logic [4:0]  prev_chan;

  rhd_acq_sequencer #(
    .NUM_CFG(3)
  ) dut (
    .clk25       (clk25),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_chan (sample_chan),
    .frame_start (frame_start),
    .busy        (busy),
    .config_done (config_done)
  );

  assign cfg_data = cfg_tab[cfg_addr];

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // one negedge step of the SPI engine model plus output checks
  task automatic tick();
    samp_t e;
    @(negedge clk25);
    if (rst) begin
      rsp_valid  = 1'b0;
      cmd_ready  = 1'b1;
      cnt        = 0;
      hold_cnt   = 0;
      spur_req   = 1'b0;
      prev_stall = 1'b0;
      acc_q.delete();
      samp_q.delete();
      return;
    end
    if (samp_q.size() > 0) begin
      e = samp_q.pop_front();
      chk("sample",
          32'({sample_valid, frame_start, sample_chan, sample_data}),
          32'({1'b1, e.fs, e.ch, e.d}));
    end else begin
      chk("no_sample", 32'({sample_valid, frame_start}), 32'd0);
    end
    if (sample_valid) begin
      if (nsamp == 0) first_chan = sample_chan;
      nsamp++;
      prev_chan = last_chan;
      last_chan = sample_chan;
    end
    if (prev_stall)
      chk("stall_hold", 32'({cmd_valid, cmd_data}),
          32'({1'b1, prev_word}));
    rsp_valid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = 16'h1000 + 16'(k);
        k++;
        if (h2[15:14] == 2'b00) begin
          e.ch = h2[12:8];
          e.d  = rsp_data;
          e.fs = (h2[12:8] == 5'd0);
          samp_q.push_back(e);
        end
        h2 = h1;
        h1 = cur;
      end
    end else if (spur_req && !cmd_valid) begin
      rsp_valid = 1'b1;
      rsp_data  = 16'hBAD0;
      spur_req  = 1'b0;
    end
    if (hold_cnt > 0) begin
      cmd_ready = 1'b0;
      hold_cnt--;
    end else begin
      cmd_ready = 1'b1;
    end
    if (cmd_valid && cmd_ready) begin
      chk("one_outstanding", 32'({cnt != 0, rsp_valid}), 32'd0);
      acc_q.push_back(cmd_data);
      cur = cmd_data;
      cnt = 2;
    end
    prev_stall = cmd_valid && !cmd_ready;
    prev_word  = cmd_data;
  endtask

  task automatic get_acc(output logic [15:0] w);
    int n;
    n = 0;
    while (acc_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    if (acc_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL acc_timeout actual=none required=command");
      w = 16'h0000;
    end else begin
      w = acc_q.pop_front();
    end
  endtask

  task automatic do_start(input logic with_stop);
    h1 = 16'hFFFF;
    h2 = 16'hFFFF;
    samp_q.delete();
    nsamp = 0;
    start = 1'b1;
    stop  = with_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("busy_on_start", 32'(busy), 32'd1);
  endtask

  initial begin
    logic [15:0] w;
    int          n;
    total = 0;
    bad = 0;
    cnt = 0;
    hold_cnt = 0;
    k = 0;
    nsamp = 0;
    spur_req = 1'b0;
    prev_stall = 1'b0;
    prev_word = 16'h0;
    h1 = 16'hFFFF;
    h2 = 16'hFFFF;
    cur = 16'hFFFF;
    first_chan = 5'd0;
    last_chan = 5'd0;
    prev_chan = 5'd0;

    vec[0] = '{cfg: {6'd0, 8'hDE}, exp: 16'h80DE};
    vec[1] = '{cfg: {6'd1, 8'h20}, exp: 16'h8120};
    vec[2] = '{cfg: {6'd2, 8'h28}, exp: 16'h8228};
    vec[3] = '{cfg: 14'h0, exp: 16'h5500};
    for (int i = 4; i < 13; i++) vec[i] = '{cfg: 14'h0, exp: 16'hE800};
    for (int i = 0; i < 32; i++) cfg_tab[i] = 14'h0;
    for (int i = 0; i < 3; i++) cfg_tab[i] = vec[i].cfg;

    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cmd_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data = 16'h0;
    repeat (3) tick();
    chk("rst_cmd", 32'({cmd_valid, cmd_data}), 32'd0);
    chk("rst_status", 32'({busy, config_done, cfg_addr}), 32'd0);
    chk("rst_sample",
        32'({sample_valid, frame_start, sample_chan, sample_data}), 32'd0);
    rst = 1'b0;
    tick();

    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("idle_stop", 32'({busy, cmd_valid}), 32'd0);

    do_start(1'b1);
    for (int i = 0; i < 13; i++) begin
      get_acc(w);
      chk("cfg_seq", 32'(w), 32'(vec[i].exp));
      chk("cfg_not_done", 32'(config_done), 32'd0);
    end

    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 32; c++) begin
        get_acc(w);
        chk("scan_cmd", 32'(w), 32'({3'b000, 5'(c), 8'h00}));
        if (f == 0 && c == 0)
          chk("config_done", 32'(config_done), 32'd1);
        if (f == 0 && c == 5) hold_cnt = 5;
        if (f == 0 && c == 15) begin
          spur_req = 1'b1;
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        if (f == 1 && c == 10) begin
          stop = 1'b1;
          tick();
          stop = 1'b0;
        end
      end
    end
    repeat (2) begin
      get_acc(w);
      chk("flush_cmd", 32'(w), 32'h0000E800);
    end
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("busy_drop", 32'(busy), 32'd0);
    chk("cfg_done_drop", 32'(config_done), 32'd0);
    repeat (10) tick();
    chk("no_cmd_after_stop", 32'(acc_q.size()), 32'd0);
    chk("last_chans", 32'({prev_chan, last_chan}), 32'({5'd30, 5'd31}));
    chk("samp_drained", 32'(samp_q.size()), 32'd0);

    do_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      get_acc(w);
      chk("cfg_seq_a", 32'(w), 32'(vec[i].exp));
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_cmd", 32'({cmd_valid, cmd_data}), 32'd0);
    chk("abort_status", 32'({busy, config_done, cfg_addr}), 32'd0);
    chk("abort_sample",
        32'({sample_valid, frame_start, sample_chan, sample_data}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_start(1'b0);
    for (int i = 0; i < 13; i++) begin
      get_acc(w);
      chk("cfg_seq_b", 32'(w), 32'(vec[i].exp));
    end
    for (int c = 0; c < 5; c++) begin
      get_acc(w);
      chk("scan_cmd_b", 32'(w), 32'({3'b000, 5'(c), 8'h00}));
    end
    chk("first_chan", 32'({nsamp > 0, first_chan}), 32'({1'b1, 5'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
